// File: rtl/layer_io_sequencer_if.sv
// Serial stream bundle for layer_io_sequencer: input word channel and output word channel.
// The master side is the sample source/sink; the slave side is the sequencer.
interface layer_io_sequencer_if;
    logic        in_valid_x70;
    logic        in_ready_x70;
    logic [31:0] in_data_x70;
    logic        out_valid_x70;
    logic        out_ready_x70;
    logic [31:0] out_data_x70;
    logic        out_last_x70;

    modport master (
        output in_valid_x70, in_data_x70, out_ready_x70,
        input  in_ready_x70, out_valid_x70, out_data_x70, out_last_x70
    );

    modport slave (
        input  in_valid_x70, in_data_x70, out_ready_x70,
        output in_ready_x70, out_valid_x70, out_data_x70, out_last_x70
    );
endinterface

// File: rtl/layer_io_sequencer.sv
// Serial-to-parallel front end and parallel-to-serial back end for the 6-in/4-out layer.
// Optional argmax class output is enabled with `define SEQ_ARGMAX_EN.
module layer_io_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk_x70,
    input  logic                 reset_n_x70,
    layer_io_sequencer_if.slave  io,
    output logic                 layer_reset_x70,
    input  logic                 layer_done_x70,
    output logic [31:0]          x1_x70,
    output logic [31:0]          x2_x70,
    output logic [31:0]          x3_x70,
    output logic [31:0]          x4_x70,
    output logic [31:0]          x5_x70,
    output logic [31:0]          x6_x70,
    input  logic [31:0]          y1_x70,
    input  logic [31:0]          y2_x70,
    input  logic [31:0]          y3_x70,
    input  logic [31:0]          y4_x70,
    output logic                 busy_x70,
    output logic                 err_timeout_x70
`ifdef SEQ_ARGMAX_EN
    ,
    output logic [1:0]           class_x70
`endif
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, SEND} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [1:0]      oidx_q, oidx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     x_q [6];
    logic [31:0]     x_d [6];
    logic [31:0]     yreg_q [4];
    logic [31:0]     yreg_d [4];
    logic [31:0]     y_w [4];
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
`ifdef SEQ_ARGMAX_EN
    logic [1:0]      cls_q, cls_d;

    // Sign bit forces a word to zero; strict compare keeps the lowest index on ties.
    function automatic logic [1:0] argmax4(input logic [31:0] w [4]);
        logic [30:0] best;
        logic [30:0] mag;
        argmax4 = '0;
        best    = w[0][31] ? '0 : w[0][30:0];
        for (int unsigned i = 1; i < 4; i++) begin
            mag = w[i][31] ? '0 : w[i][30:0];
            if (mag > best) begin
                best    = mag;
                argmax4 = i[1:0];
            end
        end
    endfunction
`endif

    assign y_w[0] = y1_x70;
    assign y_w[1] = y2_x70;
    assign y_w[2] = y3_x70;
    assign y_w[3] = y4_x70;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oidx_d  = oidx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        yreg_d  = yreg_q;
        err_d   = err_q;
`ifdef SEQ_ARGMAX_EN
        cls_d   = cls_q;
`endif
        unique case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (io.in_valid_x70 && in_ready_q) begin
                    for (int unsigned i = 0; i < 6; i++) begin
                        if (idx_q == i[2:0]) x_d[i] = io.in_data_x70;
                    end
                    if (idx_q == 3'd5) begin
                        idx_d   = '0;
                        state_d = CLEAR;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // cnt_q == 0 marks the first RUN cycle, where a done left over from the
                // previous sample may still be visible; done beats a same-cycle timeout.
                if (layer_done_x70 && (cnt_q != '0)) begin
                    yreg_d  = y_w;
`ifdef SEQ_ARGMAX_EN
                    cls_d   = argmax4(y_w);
`endif
                    state_d = SEND;
                end else if (cnt_d == TIMEOUT[CW-1:0]) begin
                    yreg_d  = '{default: '0};
`ifdef SEQ_ARGMAX_EN
                    cls_d   = '0;
`endif
                    err_d   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_valid_q && io.out_ready_x70) begin
                    if (oidx_q == 2'd3) begin
                        oidx_d  = '0;
                        state_d = LOAD;
                    end else begin
                        oidx_d = oidx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered, so they are decoded from the next state.
        in_ready_d  = (state_d == LOAD);
        out_valid_d = (state_d == SEND);
        out_last_d  = (state_d == SEND) && (oidx_d == 2'd3);
        out_data_d  = (state_d == SEND) ? yreg_d[oidx_d] : '0;
        busy_d      = (state_d inside {CLEAR, RUN, SEND});
    end

    always_ff @(posedge clk_x70 or negedge reset_n_x70) begin
        if (!reset_n_x70) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            oidx_q      <= '0;
            cnt_q       <= '0;
            x_q         <= '{default: '0};
            yreg_q      <= '{default: '0};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef SEQ_ARGMAX_EN
            cls_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            oidx_q      <= oidx_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            yreg_q      <= yreg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
`ifdef SEQ_ARGMAX_EN
            cls_q       <= cls_d;
`endif
        end
    end

    // The layer is held in reset for as long as the sequencer is.
    assign layer_reset_x70  = ~reset_n_x70 | (state_q == CLEAR);

    assign io.in_ready_x70  = in_ready_q;
    assign io.out_valid_x70 = out_valid_q;
    assign io.out_last_x70  = out_last_q;
    assign io.out_data_x70  = out_data_q;
    assign busy_x70         = busy_q;
    assign err_timeout_x70  = err_q;
    assign x1_x70           = x_q[0];
    assign x2_x70           = x_q[1];
    assign x3_x70           = x_q[2];
    assign x4_x70           = x_q[3];
    assign x5_x70           = x_q[4];
    assign x6_x70           = x_q[5];
`ifdef SEQ_ARGMAX_EN
    assign class_x70        = cls_q;
`endif
endmodule

// File: tb/tb_layer_io_sequencer.sv
// Scoreboard bench for layer_io_sequencer with a behavioural layer whose done latency is set per sample.
// Class checks are compiled in when SEQ_ARGMAX_EN is defined.
module tb_layer_io_sequencer;
    localparam int unsigned TMO = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layer_io_sequencer_if io();
    logic        layer_reset;
    logic        layer_done = 1'b0;
    logic [31:0] x1, x2, x3, x4, x5, x6, y1, y2, y3, y4;
    logic        busy, err;
`ifdef SEQ_ARGMAX_EN
    logic [1:0]  cls;
`endif

    layer_io_sequencer #(.TIMEOUT(TMO)) dut (
        .clk_x70(clk), .reset_n_x70(rst_n), .io(io),
        .layer_reset_x70(layer_reset), .layer_done_x70(layer_done),
        .x1_x70(x1), .x2_x70(x2), .x3_x70(x3), .x4_x70(x4), .x5_x70(x5), .x6_x70(x6),
        .y1_x70(y1), .y2_x70(y2), .y3_x70(y3), .y4_x70(y4),
        .busy_x70(busy), .err_timeout_x70(err)
`ifdef SEQ_ARGMAX_EN
        , .class_x70(cls)
`endif
    );

    // Behavioural layer: done rises lat cycles after its reset (lat 0 = never) and stays high.
    // With stale set, done survives the reset edge for one cycle.
    int          lat   = 18;
    bit          stale = 1'b0;
    logic [31:0] yv [4];
    int          lcnt  = 0;
    bit          fin   = 1'b0;
    always @(posedge clk) begin
        if (layer_reset) begin
            lcnt <= 0;
            fin  <= 1'b0;
            if (!stale) layer_done <= 1'b0;
        end else begin
            fin        <= fin || (lat != 0 && lcnt == lat - 1);
            layer_done <= fin || (lat != 0 && lcnt == lat - 1);
            if (!(fin || (lat != 0 && lcnt == lat - 1))) lcnt <= lcnt + 1;
        end
    end
    assign y1 = layer_done ? yv[0] : 32'h7F00_0001;
    assign y2 = layer_done ? yv[1] : 32'h7F00_0002;
    assign y3 = layer_done ? yv[2] : 32'h7F00_0003;
    assign y4 = layer_done ? yv[3] : 32'h7F00_0004;

    typedef struct {
        logic [31:0] data;
        bit          last;
        logic [1:0]  cls;
    } exp_t;
    exp_t exp_q[$];

    int n_tests    = 0;
    int n_fail     = 0;
    bit err_model  = 1'b0;
    int bp_cycles  = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic give_up(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "bench stopped");
    endtask

    // Reference class: negative words count as zero, first maximum wins.
    function automatic logic [1:0] argmax_ref(input logic [31:0] y [4]);
        int unsigned best = 0;
        int unsigned v;
        logic [1:0]  idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            v = y[i][31] ? 0 : {1'b0, y[i][30:0]};
            if (v > best) begin
                best = v;
                idx  = 2'(i);
            end
        end
        return idx;
    endfunction

    task automatic check_reset_vals(input string name);
        check({name, "_ctl"}, {io.in_ready_x70, io.out_valid_x70, io.out_last_x70, busy, err, layer_reset},
              6'b000001);
        check({name, "_data"}, {io.out_data_x70, x1, x2, x3, x4, x5, x6}, '0);
`ifdef SEQ_ARGMAX_EN
        check({name, "_class"}, cls, 2'd0);
`endif
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_after_release", {io.in_ready_x70, layer_reset}, 2'b00);
        @(negedge clk);
        check("ready_second_cycle", io.in_ready_x70, 1'b1);
    endtask

    task automatic put_word(input logic [31:0] d);
        int guard = 0;
        @(negedge clk);
        io.in_valid_x70 = 1'b1;
        io.in_data_x70  = d;
        while (!io.in_ready_x70) begin
            @(negedge clk);
            guard++;
            if (guard > 300) give_up("in_ready_wait");
        end
    endtask

    task automatic run_sample(input logic [31:0] w [6], input logic [31:0] y [4], input int l,
                              input bit st, input bit gap, input int abort_at);
        bit   tmo;
        int   exp_run, rst_cnt, run_cnt, guard;
        bit   bad_load = 1'b0;
        exp_t e;
        tmo     = (l == 0) || (l + 1 > int'(TMO));
        exp_run = tmo ? int'(TMO) : l + 1;
        for (int i = 0; i < 4; i++) begin
            e.data = tmo ? 32'h0 : y[i];
            e.last = (i == 3);
            e.cls  = tmo ? 2'd0 : argmax_ref(y);
            exp_q.push_back(e);
        end
        lat   = l;
        stale = st;
        yv    = y;
        for (int i = 0; i < 6; i++) begin
            if (gap) begin
                @(negedge clk);
                io.in_valid_x70 = 1'b0;
            end
            put_word(w[i]);
            if (i > 0 && (layer_reset || busy)) bad_load = 1'b1;
        end
        @(negedge clk);
        io.in_valid_x70 = 1'b0;
        rst_cnt = 0;
        run_cnt = 0;
        guard   = 0;
        while (!io.out_valid_x70) begin
            if (layer_reset) rst_cnt++;
            else if (busy) begin
                run_cnt++;
                if (run_cnt == 1) check("x_regs", {x1, x2, x3, x4, x5, x6}, {w[0], w[1], w[2], w[3], w[4], w[5]});
                if (run_cnt == abort_at) begin
                    #2 rst_n = 1'b0;
                    #1 check_reset_vals("run_abort");
                    exp_q.delete();
                    err_model = 1'b0;
                    @(negedge clk);
                    release_reset();
                    return;
                end
            end
            @(negedge clk);
            guard++;
            if (guard > 200) give_up("out_valid_wait");
        end
        err_model = err_model | tmo;
        check("load_no_early_clear", bad_load, 1'b0);
        check("clear_pulse", rst_cnt, 1);
        check("run_cycles", run_cnt, exp_run);
        check("err_flag", err, err_model);
    endtask

    // Monitor: drives out_ready, compares every presented word with the scoreboard head.
    initial begin : monitor
        bit   after_last = 1'b0;
        exp_t e;
        io.out_ready_x70 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                after_last       = 1'b0;
                io.out_ready_x70 = 1'b0;
                continue;
            end
            if (after_last) begin
                check("next_load", {io.in_ready_x70, busy, io.out_valid_x70}, 3'b100);
                after_last = 1'b0;
            end
            if (io.out_valid_x70 && bp_cycles > 0) begin
                io.out_ready_x70 = 1'b0;
                bp_cycles--;
            end else begin
                io.out_ready_x70 = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (io.out_valid_x70) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_unexpected: got %0h expected no word", io.out_data_x70);
                end else begin
                    e = exp_q[0];
                    check(io.out_ready_x70 ? "out_word" : "out_hold",
                          {io.out_last_x70, io.out_data_x70}, {e.last, e.data});
`ifdef SEQ_ARGMAX_EN
                    check("class", cls, e.cls);
`endif
                    if (io.out_ready_x70) begin
                        void'(exp_q.pop_front());
                        after_last = e.last;
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] wv [6];
        logic [31:0] yw [4];
        int          guard;
        io.in_valid_x70 = 1'b0;
        io.in_data_x70  = '0;
        yv              = '{default: '0};
        repeat (2) @(negedge clk);
        #1 check_reset_vals("por");
        release_reset();

        wv = '{32'h3F80_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        yw = '{32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, 32'hBF80_0000};
        run_sample(wv, yw, 18, 1'b0, 1'b0, 0);

        wv = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        yw = '{32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 32'h0};
        run_sample(wv, yw, 18, 1'b0, 1'b1, 0);

        bp_cycles = 5;
        wv = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h1234_5678, 32'h8765_4321, 32'hFFFF_FFFF, 32'h0000_0001};
        yw = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        run_sample(wv, yw, 7, 1'b0, 1'b0, 0);

        yw = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        run_sample(wv, yw, 18, 1'b1, 1'b0, 0);
        yw = '{32'h0000_0005, 32'h8000_0009, 32'h0000_0007, 32'h0000_0007};
        run_sample(wv, yw, 63, 1'b1, 1'b0, 0);
        run_sample(wv, yw, 64, 1'b0, 1'b0, 0);
        run_sample(wv, yw, 0, 1'b1, 1'b0, 0);
        yw = '{32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000};
        run_sample(wv, yw, 12, 1'b1, 1'b0, 0);

        run_sample(wv, yw, 18, 1'b0, 1'b0, 5);
        wv = '{32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004, 32'hC0DE_0005, 32'hC0DE_0006};
        run_sample(wv, yw, 18, 1'b0, 1'b0, 0);

        for (int i = 0; i < 3; i++) put_word(32'hBAD0_0000 + 32'(i));
        @(negedge clk);
        io.in_valid_x70 = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("load_abort");
        @(negedge clk);
        release_reset();
        wv = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044, 32'h0000_0055, 32'h0000_0066};
        run_sample(wv, yw, 3, 1'b0, 1'b0, 0);

        rand_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int l;
            for (int i = 0; i < 6; i++) wv[i] = $urandom();
            for (int i = 0; i < 4; i++) begin
                yw[i] = $urandom();
                if ($urandom_range(0, 1) == 1) yw[i][31] = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) yw[2] = yw[0];
            l = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 30));
            run_sample(wv, yw, l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        guard = 0;
        while (exp_q.size() != 0 || io.out_valid_x70) begin
            @(negedge clk);
            guard++;
            if (guard > 500) give_up("drain_wait");
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        give_up("global_time_limit");
    end
endmodule

// File: doc/layer_io_sequencer.md
# layer_io_sequencer

Streaming front/back-end for the 6-input, 4-output hidden layer.
- Accepts a sample as six serial 32-bit IEEE-754 words, assembles them onto the layer's parallel `x1..x6` inputs, and restarts the layer with a one-cycle reset.
- Waits for the layer's `done`, captures `y1..y4`, and streams them out serially under valid/ready.
- Sits between the sample source (testbench/DMA) and the layer instance, which has no handshake of its own.

## Interface
- `TIMEOUT`, 64: maximum RUN cycles waiting for `layer_done_x70` before declaring an error.
- `clk_x70`  in  1  single clock; everything is on posedge.
- `reset_n_x70`  in  1  asynchronous, active-low reset.
- `in_valid_x70`  in  1  input word valid.
- `in_ready_x70`  out  1  sequencer accepts an input word.
- `in_data_x70`  in  32  input word (float bits); the first word of a sample is x1.
- `layer_reset_x70`  out  1  active-high reset to the layer, synchronous from the layer's side.
- `layer_done_x70`  in  1  layer completion flag.
- `x1_x70`..`x6_x70`  out  32 each  parallel layer inputs.
- `y1_x70`..`y4_x70`  in  32 each  layer outputs (post-ReLU).
- `out_valid_x70`  out  1  output word valid.
- `out_ready_x70`  in  1  sink accepts an output word.
- `out_data_x70`  out  32  output word, in order y1..y4.
- `out_last_x70`  out  1  high with the y4 word.
- `busy_x70`  out  1  high in CLEAR, RUN and SEND.
- `err_timeout_x70`  out  1  sticky timeout flag.
- `class_x70`  out  2  argmax index; present only with `SEQ_ARGMAX_EN`.

## Operation
- **States:** IDLE, LOAD, CLEAR, RUN, SEND.
  - IDLE → LOAD unconditionally.
  - LOAD → CLEAR when the 6th word is accepted.
  - CLEAR → RUN after 1 cycle.
  - RUN → SEND on `layer_done_x70`, or on timeout.
  - SEND → LOAD on the handshake of the last word.
- **LOAD**
  - `in_ready_x70` = 1.
  - Each `in_valid&&in_ready` writes `in_data` into `x[idx]` and increments `idx` (0..5).
  - Gaps in `in_valid` are allowed.
  - `x1..x6` are registers and hold from acceptance until overwritten in the next LOAD, so they are stable throughout RUN.
- **CLEAR**
  - `layer_reset_x70` = 1 for exactly one cycle.
  - The timeout counter is cleared.
- **RUN**
  - `layer_reset_x70` = 0.
  - `layer_done_x70` is ignored in the first RUN cycle (guards against a stale done).
  - From the second cycle on, `done` = 1 latches `y1..y4` into the output registers.
  - The counter increments each RUN cycle. On reaching `TIMEOUT` with no `done`:
    - output registers are loaded with 0;
    - `err_timeout_x70` is set;
    - the state goes to SEND.
- **SEND**
  - `out_valid_x70` = 1 and `out_data_x70` = `yreg[oidx]`.
  - `oidx` advances on each handshake; `out_last_x70` = (`oidx` == 3).
  - `out_data` and `out_last` are held stable while `out_ready` = 0.
- **Errors:** `err_timeout_x70` clears only on reset; later samples still process normally.
- **Reset:** a mid-operation reset aborts the sample. Partial input is discarded, and `idx`, `oidx` and the counter all return to 0.

## Timing
- **Reset values:**
  - state IDLE;
  - `in_ready` 0, `out_valid` 0, `out_last` 0, `busy` 0, `err_timeout` 0;
  - `out_data` 0, `x1..x6` 0, `class` 0.
- **`layer_reset_x70`:**
  - 1 while `reset_n_x70` = 0 (combinational OR of async reset and the CLEAR state), so the layer is held in reset.
  - 0 in IDLE after reset release.
- **Registered outputs:** `in_ready` rises on the first edge after reset release (IDLE), i.e. in the second cycle.
- **Latency:**
  - the 6th input handshake at edge N enters CLEAR at N;
  - `layer_reset` is high during cycle N+1;
  - RUN starts at N+1;
  - with the standard layer (`done` ~18 cycles after reset), `out_valid` rises ~20 cycles after the 6th word.
- **Back-to-back:** the cycle after the last output handshake is LOAD with `in_ready` = 1. There is no overlap between samples.
- **Simultaneous events:** a done and a timeout in the same cycle are resolved in favour of done; no error is raised.

## Configuration
- `SEQ_ARGMAX_EN` defined:
  - `class_x70` is registered at capture as the index (0..3) of the largest `y`;
  - the comparison is unsigned on bits [30:0], valid because ReLU outputs are non-negative;
  - any word with bit 31 set is treated as 0;
  - ties resolve to the lowest index;
  - the value is stable for the whole of SEND; on a timeout it is 0.
- Not defined: the `class_x70` port and its logic are absent.

## Test plan
- **Basic flow.** Behavioural layer (done 18 cycles after its reset, y = 3F800000, 40000000, 00000000, BF800000); inputs 3F800000 then five zeros:
  - `x1` = 3F800000 and `x2..x6` = 0 during RUN;
  - `layer_reset` is high for exactly 1 cycle;
  - output words arrive in order, with `out_last` on the 4th;
  - `class_x70` = 1.
- **Gapped input.** `in_valid` alternating 1/0 with words 1..6 → `x1..x6` = words 1..6; CLEAR occurs only after the 6th handshake.
- **Backpressure.** `out_ready` held 0 for 5 cycles in SEND → `out_valid` stays 1 and `out_data` is unchanged; releasing it completes the 4 words with no loss or duplication.
- **Timeout.** The layer never asserts done, `TIMEOUT` = 64 → SEND entered exactly 64 RUN cycles later, four 00000000 words, `err_timeout` = 1; the next good sample passes with the flag still 1.
- **Reset in RUN.** `reset_n` driven low in RUN → all outputs reach their reset values immediately and `layer_reset` = 1; after release, the next input word lands in `x1`.
- **Tie case.** y = 3F800000 ×4 → `class_x70` = 0; a second back-to-back sample is accepted the cycle after the first sample's last output.
